// File: rtl/data_memory.sv
// Off-chip main-memory model behind the data cache: one outstanding whole-line
// request at a time, completed after a fixed latency with a single-cycle ack.
module data_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      addr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    input  logic             write_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic [WIDTH-1:0] memory [DEPTH];

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_nextCnt;
    logic [AW-1:0]    r_index;
    logic [WIDTH-1:0] r_data;
    logic             r_write;
    logic             w_latch;
    logic             w_ack;
    logic [AW-1:0]    w_index;

    // Byte offset within a line and address bits above the array wrap are dropped.
    assign w_index = addr_i[5 +: AW];
    logic w_unusedAddrBits;
    assign w_unusedAddrBits = ^{addr_i[31:5+AW], addr_i[4:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_latch     = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_latch     = 1'b1;
                    w_nextState = BUSY;
                    w_nextCnt   = '0;
                end
            end
            BUSY: begin
                if (r_cnt == LAST_CNT) begin
                    w_ack       = 1'b1;
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    // Request fields are captured only when accepted; later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_index <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
        end else if (w_latch) begin
            r_index <= w_index;
            r_data  <= data_i;
            r_write <= write_i;
        end
    end

    // Storage is never cleared; a reset in the ack cycle suppresses the commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_ack && r_write) begin
            memory[r_index] <= r_data;
        end
    end

    assign ack_o  = w_ack;
    assign data_o = (w_ack && !r_write) ? memory[r_index] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// read/write traffic checked against a line-array reference model.
module tb_data_memory;

   localparam int LATENCY = 10;
   localparam int DEPTH   = 512;
   localparam int WIDTH   = 256;

   logic             clk_i;
   logic             rst_i;
   logic [31:0]      addr_i;
   logic [WIDTH-1:0] data_i;
   logic             enable_i;
   logic             write_i;
   logic             ack_o;
   logic [WIDTH-1:0] data_o;

   logic [WIDTH-1:0] refMem [DEPTH];
   int vectors;
   int miscompares;

   data_memory #(
      .LATENCY(LATENCY),
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .enable_i(enable_i),
      .write_i (write_i),
      .ack_o   (ack_o),
      .data_o  (data_o)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [WIDTH-1:0] rand256();
      logic [WIDTH-1:0] v;
      for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int lineOf(input logic [31:0] a);
      return int'(a[13:5]);
   endfunction

   // Single comparison point: counts every vector and every miscompare.
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; the next rising edge samples it.
   task automatic applyStimulus(input logic [31:0] a, input logic [WIDTH-1:0] d, input logic w);
      @(negedge clk_i);
      enable_i = 1'b1;
      addr_i   = a;
      data_i   = d;
      write_i  = w;
   endtask

   // Watch each cycle until the ack, checking quiet data_o, the ack position and
   // the returned line; optionally scramble the request inputs while busy.
   task automatic waitAck(input string tag, input logic [WIDTH-1:0] expData, input int expLat,
                          input bit scramble, input bit releaseEn);
      int lat;
      lat = -1;
      for (int k = 1; k <= expLat + 4; k++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) begin
            lat = k;
            checkOutput({tag, ".data"}, data_o, expData);
            if (releaseEn) enable_i = 1'b0;
            break;
         end
         checkOutput({tag, ".quiet"}, data_o, '0);
         if (scramble) begin
            addr_i  = $urandom;
            data_i  = rand256();
            write_i = 1'($urandom);
         end
      end
      checkOutput({tag, ".latency"}, WIDTH'(lat), WIDTH'(expLat));
      if (releaseEn) begin
         @(negedge clk_i);
         checkOutput({tag, ".pulse"}, {{(WIDTH-1){1'b0}}, ack_o}, '0);
         checkOutput({tag, ".after"}, data_o, '0);
      end
   endtask

   // Full transaction against the reference model.
   task automatic doRequest(input string tag, input logic [31:0] a, input logic [WIDTH-1:0] d,
                            input logic w, input bit scramble);
      logic [WIDTH-1:0] expData;
      expData = w ? '0 : refMem[lineOf(a)];
      applyStimulus(a, d, w);
      waitAck(tag, expData, LATENCY, scramble, 1'b1);
      if (w) refMem[lineOf(a)] = d;
   endtask

   initial begin
      logic [WIDTH-1:0] lost;
      logic [WIDTH-1:0] keep;
      vectors     = 0;
      miscompares = 0;
      rst_i       = 1'b1;
      enable_i    = 1'b0;
      addr_i      = '0;
      data_i      = '0;
      write_i     = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         refMem[i]     = rand256();
         dut.memory[i] = refMem[i];
      end
      refMem[0]     = 256'h5;
      dut.memory[0] = 256'h5;

      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      checkOutput("reset.ack", {{(WIDTH-1){1'b0}}, ack_o}, '0);
      checkOutput("reset.data", data_o, '0);

      $display("[TB] basic read of preloaded line 0");
      doRequest("read0", 32'h0, '0, 1'b0, 1'b0);

      $display("[TB] write line 32, then read it back");
      doRequest("wr400", 32'h400, 256'hDEAD_BEEF, 1'b1, 1'b0);
      checkOutput("wr400.mem32", dut.memory[32], 256'hDEAD_BEEF);
      checkOutput("wr400.mem0", dut.memory[0], 256'h5);
      doRequest("rd400", 32'h400, '0, 1'b0, 1'b0);

      $display("[TB] aliasing and byte offset");
      doRequest("wr4000", 32'h4000, 256'h7, 1'b1, 1'b0);
      doRequest("rd1F", 32'h1F, '0, 1'b0, 1'b0);

      $display("[TB] inputs scrambled while busy");
      keep = rand256();
      doRequest("midBusyWr", 32'h60, keep, 1'b1, 1'b1);
      checkOutput("midBusyWr.mem3", dut.memory[3], keep);
      doRequest("midBusyRd", 32'h60, '0, 1'b0, 1'b1);

      $display("[TB] reset in the middle of a write");
      lost = rand256();
      applyStimulus(32'h20, lost, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_i);
         checkOutput("rstMid.noAck", {{(WIDTH-1){1'b0}}, ack_o}, '0);
      end
      rst_i    = 1'b1;
      enable_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
         checkOutput("rstMid.idle", {{(WIDTH-1){1'b0}}, ack_o}, '0);
         @(negedge clk_i);
      end
      checkOutput("rstMid.mem1", dut.memory[1], refMem[1]);
      doRequest("rstMid.read", 32'h20, '0, 1'b0, 1'b0);

      $display("[TB] enable held across two reads");
      applyStimulus(32'h0, '0, 1'b0);
      waitAck("hold.first", refMem[0], LATENCY, 1'b0, 1'b0);
      addr_i = 32'h20;
      waitAck("hold.second", refMem[1], LATENCY + 1, 1'b0, 1'b1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = (n % 4 == 0) ? {$urandom_range(0, 3) << 14} | 32'(($urandom_range(0, 3)) << 5) : $urandom;
         doRequest("rand", a, rand256(), 1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput("rand.memLine", dut.memory[i], refMem[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute backstop so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
